// File: rtl/pos_cell_pingpong_mem.sv
// pos_cell_pingpong_mem
//  Double-buffered (ping-pong) particle position store for one cell. Readers
//  (force evaluation) see the active bank; the motion-update path appends
//  particles to the shadow bank. A swap handshake exchanges the banks between
//  timesteps, after draining any in-flight reads.
//
//  Word 0 of a bank is the particle count (held in a register, not the RAM);
//  particles live at 1..PARTICLE_NUM-1.
//
// Ports
//  i_clk, i_rst             clock, async active-high reset
//  i_rd_en, i_rd_addr       read request into the active bank (taken when o_rd_ready)
//  o_rd_ready               read port accepting requests (0 during DRAIN/SWAP)
//  o_rd_valid, o_rd_data    read response, fixed 2-cycle latency, pipelined
//  i_wr_en, i_wr_data       append a particle to the shadow bank (taken when o_wr_ready)
//  o_wr_ready               write port accepting requests (0 only in SWAP)
//  i_swap_req / o_swap_done 1-cycle request / completion pulses for a bank exchange
//  o_active_bank            bank currently served to readers
//  o_wr_overflow            sticky: a write was dropped because the shadow bank was full
//  o_parity_err             (POS_CELL_PARITY_EN only) parity mismatch, aligned with o_rd_valid
//
// Build option
//  POS_CELL_PARITY_EN : store an even-parity bit per word and check it on read.
module pos_cell_pingpong_mem #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int INIT_COUNT   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_swap_req,
  output logic                  o_swap_done,
  output logic                  o_active_bank,
  output logic                  o_wr_overflow
`ifdef POS_CELL_PARITY_EN
  ,
  output logic                  o_parity_err
`endif
);

`ifdef POS_CELL_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  // wr_ptr needs one extra bit so it can reach PARTICLE_NUM (the "full" mark)
  localparam logic [ADDR_WIDTH:0] PN = PARTICLE_NUM[ADDR_WIDTH:0];

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWAP} state_t;

  state_t                r_state, w_next;
  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_act_cnt;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic                  r_ovf, r_swap_done;
  logic [2:1]            r_vld_pipe;
  logic                  r_s1_zero, r_s1_oor;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_perr;

  logic                  w_rd_ready, w_wr_ready;
  logic                  w_rd_acc, w_wr_acc, w_wr_do, w_in_rng;
  logic [ADDR_WIDTH-1:0] w_raddr, w_widx;
  logic [ADDR_WIDTH:0]   w_ptr_m1;
  logic [MW-1:0]         w_wr_word, w_q;

  logic [MW-1:0] r_bank0 [PARTICLE_NUM];
  logic [MW-1:0] r_bank1 [PARTICLE_NUM];
  logic [MW-1:0] r_q0, r_q1;

  // ---------------- control FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next     = r_state;
    w_rd_ready = 1'b1;
    w_wr_ready = 1'b1;
    case (r_state)
      S_IDLE:  if (i_swap_req) w_next = S_DRAIN;
      S_DRAIN: begin
        w_rd_ready = 1'b0;
        // stage-1 empty means every accepted read already holds its RAM data
        if (!r_vld_pipe[1]) w_next = S_SWAP;
      end
      S_SWAP: begin
        w_rd_ready = 1'b0;
        w_wr_ready = 1'b0;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rd_acc = i_rd_en && w_rd_ready;
  assign w_wr_acc = i_wr_en && w_wr_ready;
  assign w_wr_do  = w_wr_acc && (r_wr_ptr != PN);
  assign w_widx   = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_ptr_m1 = r_wr_ptr - 1'b1;
  assign w_in_rng = {1'b0, i_rd_addr} < PN;
  assign w_raddr  = w_in_rng ? i_rd_addr : '0;

`ifdef POS_CELL_PARITY_EN
  assign w_wr_word = {^i_wr_data, i_wr_data};
`else
  assign w_wr_word = i_wr_data;
`endif

  // ---------------- bank / pointer state ----------------
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_active    <= 1'b0;
      r_act_cnt   <= ADDR_WIDTH'(INIT_COUNT);
      r_wr_ptr    <= (ADDR_WIDTH+1)'(1);
      r_ovf       <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= (r_state == S_SWAP);
      if (r_state == S_SWAP) begin
        r_active  <= ~r_active;
        r_act_cnt <= w_ptr_m1[ADDR_WIDTH-1:0];
        r_wr_ptr  <= (ADDR_WIDTH+1)'(1);
      end else if (w_wr_acc) begin
        if (r_wr_ptr == PN) r_ovf    <= 1'b1;
        else                r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end

  // ---------------- RAM banks ----------------
  // shadow bank is the one not active; reads and writes never share a bank
  always_ff @(posedge i_clk) begin
    if (w_wr_do && r_active) r_bank0[w_widx] <= w_wr_word;
    if (w_rd_acc)            r_q0 <= r_bank0[w_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_do && !r_active) r_bank1[w_widx] <= w_wr_word;
    if (w_rd_acc)             r_q1 <= r_bank1[w_raddr];
  end

  // active bank cannot change between stage 1 and 2: swap waits for the drain
  assign w_q = r_active ? r_q1 : r_q0;

  // ---------------- read pipeline ----------------
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_rd_data  <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_rd_acc};
      if (w_rd_acc) begin
        r_s1_zero <= (i_rd_addr == '0);
        r_s1_oor  <= !w_in_rng;
      end
      if (r_vld_pipe[1])
        r_rd_data <= r_s1_zero ? DATA_WIDTH'(r_act_cnt) :
                     r_s1_oor  ? '0 : w_q[DATA_WIDTH-1:0];
      // even parity: XOR over data+parity bit must be 0; count word not checked
      r_perr <= r_vld_pipe[1] && !r_s1_zero && !r_s1_oor && (^w_q);
    end

  assign o_rd_ready    = w_rd_ready;
  assign o_wr_ready    = w_wr_ready;
  assign o_rd_valid    = r_vld_pipe[2];
  assign o_rd_data     = r_rd_data;
  assign o_swap_done   = r_swap_done;
  assign o_active_bank = r_active;
  assign o_wr_overflow = r_ovf;
`ifdef POS_CELL_PARITY_EN
  assign o_parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_pos_cell_pingpong_mem.sv
// Self-checking bench for pos_cell_pingpong_mem (INIT_COUNT=3, default sizes).
module tb_pos_cell_pingpong_mem;
  localparam int DW = 96, PN = 220, AW = 8, IC = 3;

  logic          clk = 1'b0, rst;
  logic          rd_en, rd_ready, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, wr_data;
  logic          wr_en, wr_ready, swap_req, swap_done, active_bank, wr_overflow;
`ifdef POS_CELL_PARITY_EN
  logic          parity_err;
`endif

  pos_cell_pingpong_mem #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .INIT_COUNT(IC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_swap_req(swap_req), .o_swap_done(swap_done),
    .o_active_bank(active_bank), .o_wr_overflow(wr_overflow)
`ifdef POS_CELL_PARITY_EN
    , .o_parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt [8];

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] u;
    u = k;
    return {u ^ 32'hA5A5_0000, u * 32'd7 + 32'd1, 32'hC0DE_0000 | u};
  endfunction

  // single read, checks the 2-cycle latency and data
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chkb({nm, "_v+1"}, rd_valid, 1'b0);
    step();
    chkb({nm, "_v+2"}, rd_valid, 1'b1);
    chkd({nm, "_data"}, rd_data, exp);
  endtask

  // pulse swap_req, return cycles until swap_done (-1 if never within 8)
  task automatic do_swap(output int lat);
    lat = -1;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (swap_done) begin lat = c; break; end
      step();
    end
  endtask

  logic [DW-1:0] w1, wx, wy;
  int            lat;
  logic          seen;

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_data = '0; swap_req = 1'b0;
    w1 = pat(777);
    // bank 0 contents normally come from an init file
`ifdef POS_CELL_PARITY_EN
    dut.r_bank0[1] = {^w1, w1};
`else
    dut.r_bank0[1] = w1;
`endif
    step(); step();
    rst = 1'b0;
    step();

    // ---- reset state ----
    chkb("rst_active_bank", active_bank, 1'b0);
    chkb("rst_rd_ready", rd_ready, 1'b1);
    chkb("rst_wr_ready", wr_ready, 1'b1);
    chkb("rst_rd_valid", rd_valid, 1'b0);
    chkd("rst_rd_data", rd_data, '0);
    chkb("rst_swap_done", swap_done, 1'b0);
    chkb("rst_wr_overflow", wr_overflow, 1'b0);

    // ---- back-to-back reads addr 0,1 ----
    rd_en = 1'b1; rd_addr = 8'd0;
    step();
    chkb("b2b_v1", rd_valid, 1'b0);
    rd_addr = 8'd1;
    step();
    rd_en = 1'b0;
    chkb("b2b_v2", rd_valid, 1'b1);
    chkd("b2b_cnt", rd_data, DW'(IC));
    step();
    chkb("b2b_v3", rd_valid, 1'b1);
    chkd("b2b_word1", rd_data, w1);
    step();
    chkb("b2b_v4", rd_valid, 1'b0);

    // ---- write 5, swap, table-driven readback ----
    for (int k = 1; k <= 5; k++) begin
      wr_en = 1'b1; wr_data = pat(k);
      step();
    end
    wr_en = 1'b0;
    do_swap(lat);
    chkb("swap1_lat", (lat >= 1 && lat <= 4), 1'b1);
    chkb("swap1_bank", active_bank, 1'b1);

    vt[0] = '{8'd0,   DW'(5)};
    vt[1] = '{8'd1,   pat(1)};
    vt[2] = '{8'd2,   pat(2)};
    vt[3] = '{8'd3,   pat(3)};
    vt[4] = '{8'd4,   pat(4)};
    vt[5] = '{8'd5,   pat(5)};
    vt[6] = '{8'd220, '0};
    vt[7] = '{8'd255, '0};
    for (int i = 0; i < 8; i++)
      rd(vt[i].addr, vt[i].exp, $sformatf("tbl%0d", i));

    // ---- read + write + swap_req together, write in DRAIN ----
    wx = pat(901); wy = pat(902);
    rd_en = 1'b1; rd_addr = 8'd2; swap_req = 1'b1; wr_en = 1'b1; wr_data = wx;
    step();
    rd_en = 1'b0; swap_req = 1'b0; wr_data = wy;
    chkb("sim_drain_rd_ready", rd_ready, 1'b0);
    chkb("sim_drain_wr_ready", wr_ready, 1'b1);
    step();
    wr_en = 1'b0;
    chkb("sim_rd_valid", rd_valid, 1'b1);
    chkd("sim_rd_old_data", rd_data, pat(2));
    chkb("sim_rd_ready2", rd_ready, 1'b0);
    chkb("sim_no_done_yet", swap_done, 1'b0);
    step();
    chkb("sim_swap_rd_ready", rd_ready, 1'b0);
    chkb("sim_swap_wr_ready", wr_ready, 1'b0);
    step();
    chkb("sim_done", swap_done, 1'b1);
    chkb("sim_done_rd_ready", rd_ready, 1'b1);
    chkb("sim_bank", active_bank, 1'b0);
    rd(8'd0, DW'(2), "sim_cnt");
    rd(8'd1, wx, "sim_w_with_req");
    rd(8'd2, wy, "sim_w_in_drain");

    // ---- overflow: PN writes without swap ----
    for (int k = 0; k < PN; k++) begin
      if (k == PN - 1) chkb("ovf_before", wr_overflow, 1'b0);
      wr_en = 1'b1; wr_data = pat(100 + k);
      step();
    end
    wr_en = 1'b0;
    chkb("ovf_set", wr_overflow, 1'b1);
    do_swap(lat);
    chkb("ovf_swap_lat", (lat >= 1 && lat <= 4), 1'b1);
    chkb("ovf_sticky", wr_overflow, 1'b1);
    rd(8'd0, DW'(PN - 1), "ovf_cnt");
    rd(8'(PN - 1), pat(100 + PN - 2), "ovf_last");

    // ---- reset during DRAIN with a read in flight ----
    rd_en = 1'b1; rd_addr = 8'd1; swap_req = 1'b1;
    step();
    rd_en = 1'b0; swap_req = 1'b0;
    rst = 1'b1;
    step();
    chkb("rstdr_rd_valid", rd_valid, 1'b0);
    rst = 1'b0;
    chkb("rstdr_bank", active_bank, 1'b0);
    chkb("rstdr_ovf_clr", wr_overflow, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (swap_done || rd_valid) seen = 1'b1;
      step();
    end
    chkb("rstdr_no_done", seen, 1'b0);
    rd(8'd0, DW'(IC), "rstdr_cnt");

`ifdef POS_CELL_PARITY_EN
    // ---- parity: corrupt stored word 2 ----
    for (int k = 1; k <= 3; k++) begin
      wr_en = 1'b1; wr_data = pat(50 + k);
      step();
    end
    wr_en = 1'b0;
    do_swap(lat);
    dut.r_bank1[2][0] = ~dut.r_bank1[2][0];
    rd_en = 1'b1; rd_addr = 8'd1;
    step();
    rd_addr = 8'd2;
    step();
    rd_en = 1'b0;
    chkb("par_v1", rd_valid, 1'b1);
    chkb("par_clean", parity_err, 1'b0);
    step();
    chkb("par_v2", rd_valid, 1'b1);
    chkb("par_err", parity_err, 1'b1);
    step();
    chkb("par_pulse_end", parity_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end
endmodule
